// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants and helpers for the MIPS pipeline blocks.
//   XLEN / JIDX_W       : datapath width and jump-index width
//   RESET_PC_DEFAULT    : default fetch address after reset
//   NOP_INSTR_DEFAULT   : default bubble instruction (sll $0,$0,0)
//   pc_sel_e            : next-PC source chosen by the fetch stage
//   word_align()        : clears the byte-offset bits of an address
package mips_pkg;

    localparam int XLEN   = 32;
    localparam int JIDX_W = 26;

    localparam logic [XLEN-1:0] INSTR_BYTES       = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Listed from lowest to highest priority.
    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_HOLD   = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_BRANCH = 2'd3
    } pc_sel_e;

    // Every value loaded into the PC goes through this so the PC can
    // never become misaligned, whatever the resolving stage hands us.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage: owns the PC, addresses a combinational
// instruction memory and registers the fetched word into IF/ID.
//
// Ports
//   clk, reset          : clock (rising edge) and async active-high reset
//   stall               : decode not ready; hold PC and IF/ID
//   br_taken            : branch resolved taken this cycle
//   br_pc_plus4         : PC+4 of the branch
//   br_sign_imm         : sign-extended branch offset in words
//   jump                : jump resolved this cycle
//   jump_pc_plus4       : PC+4 of the jump
//   jump_index          : Instr[25:0] of the jump
//   imem_addr           : address to instruction memory (= pc)
//   imem_rdata          : instruction word for imem_addr, same cycle
//   pc                  : registered fetch PC
//   if_id_instr         : registered instruction for decode
//   if_id_pc_plus4      : registered PC+4 of if_id_instr
//   if_id_valid         : 1 = real instruction, 0 = bubble
//   fetch_count         : instructions accepted into IF/ID since reset
//
// Handshake: IF/ID is a one-entry register towards decode. On every rising
// edge where stall=0 and no redirect is present, decode is taken to have
// consumed the current IF/ID content and the word fetched at pc replaces
// it. stall=1 means decode is not ready, so pc and IF/ID hold. A redirect
// (br_taken or jump) always wins: the wrong-path word is discarded, a
// bubble is inserted and pc jumps, regardless of stall.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [XLEN-1:0]   br_pc_plus4,
    input  logic [XLEN-1:0]   br_sign_imm,
    input  logic              jump,
    input  logic [XLEN-1:0]   jump_pc_plus4,
    input  logic [JIDX_W-1:0] jump_index,
    output logic [XLEN-1:0]   imem_addr,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   if_id_instr,
    output logic [XLEN-1:0]   if_id_pc_plus4,
    output logic              if_id_valid,
    output logic [XLEN-1:0]   fetch_count
);

    pc_sel_e         pc_sel;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jump_target;

    assign imem_addr = pc;

    // 32-bit add wraps naturally from 0xFFFF_FFFC to 0.
    assign pc_plus4 = pc + INSTR_BYTES;

    // Offset is in words; the shift drops the top two bits, giving
    // modulo-2^32 arithmetic for negative and positive offsets alike.
    assign br_target   = word_align(br_pc_plus4 + (br_sign_imm << 2));
    assign jump_target = word_align({jump_pc_plus4[XLEN-1:XLEN-4], jump_index, 2'b00});

    always_comb begin
        pc_sel = SEL_SEQ;
        if (br_taken) begin
            pc_sel = SEL_BRANCH;
        end else if (jump) begin
            pc_sel = SEL_JUMP;
        end else if (stall) begin
            pc_sel = SEL_HOLD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= word_align(RESET_PC);
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
            fetch_count    <= '0;
        end else begin
            unique case (pc_sel)
                SEL_BRANCH, SEL_JUMP: begin
                    // Flush: the word at pc is wrong-path, replace with a
                    // bubble. if_id_pc_plus4 is left as is; it is
                    // meaningless while if_id_valid=0.
                    pc          <= (pc_sel == SEL_BRANCH) ? br_target : jump_target;
                    if_id_instr <= NOP_INSTR;
                    if_id_valid <= 1'b0;
                end
                SEL_HOLD: begin
                    // Everything holds.
                end
                SEL_SEQ: begin
                    pc             <= pc_plus4;
                    if_id_instr    <= imem_rdata;
                    if_id_pc_plus4 <= pc_plus4;
                    if_id_valid    <= 1'b1;
                    fetch_count    <= fetch_count + 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TB_NOP      = 32'h0000_0020;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_pc_plus4;
    logic [31:0] br_sign_imm;
    logic        jump;
    logic [31:0] jump_pc_plus4;
    logic [25:0] jump_index;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC  (TB_RESET_PC),
        .NOP_INSTR (TB_NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .br_taken       (br_taken),
        .br_pc_plus4    (br_pc_plus4),
        .br_sign_imm    (br_sign_imm),
        .jump           (jump),
        .jump_pc_plus4  (jump_pc_plus4),
        .jump_index     (jump_index),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_count    (fetch_count)
    );

    // Behavioural instruction memory: fixed word at 0, address hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check32({tag, "_pc"}, pc, TB_RESET_PC);
        check32({tag, "_addr"}, imem_addr, TB_RESET_PC);
        check32({tag, "_instr"}, if_id_instr, TB_NOP);
        check32({tag, "_pp4"}, if_id_pc_plus4, 32'h0);
        check32({tag, "_valid"}, {31'd0, if_id_valid}, 32'h0);
        check32({tag, "_fc"}, fetch_count, 32'h0);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic s, input logic bt, input logic [31:0] bp4,
                         input logic [31:0] bimm, input logic j,
                         input logic [31:0] jp4, input logic [25:0] jidx);
        stall         = s;
        br_taken      = bt;
        br_pc_plus4   = bp4;
        br_sign_imm   = bimm;
        jump          = j;
        jump_pc_plus4 = jp4;
        jump_index    = jidx;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        stall;
        logic        br_taken;
        logic [31:0] br_pc_plus4;
        logic [31:0] br_sign_imm;
        logic        jump;
        logic [31:0] jump_pc_plus4;
        logic [25:0] jump_index;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic [31:0] exp_pp4;
        logic        chk_pp4;
        logic        exp_valid;
        logic [31:0] exp_fc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic bt, input logic [31:0] bp4,
                                input logic [31:0] bimm, input logic j,
                                input logic [31:0] jp4, input logic [25:0] jidx,
                                input logic [31:0] epc, input logic [31:0] einstr,
                                input logic [31:0] epp4, input logic cpp4,
                                input logic evalid, input logic [31:0] efc);
        vec_t v;
        v.stall = s; v.br_taken = bt; v.br_pc_plus4 = bp4; v.br_sign_imm = bimm;
        v.jump = j; v.jump_pc_plus4 = jp4; v.jump_index = jidx;
        v.exp_pc = epc; v.exp_instr = einstr; v.exp_pp4 = epp4; v.chk_pp4 = cpp4;
        v.exp_valid = evalid; v.exp_fc = efc;
        return v;
    endfunction

    // ---------------- reference model for random phase ----------------
    logic [31:0] m_pc, m_instr, m_pp4, m_fc;
    logic        m_valid;

    task automatic model_step(input logic s, input logic bt, input logic [31:0] bp4,
                              input logic [31:0] bimm, input logic j,
                              input logic [31:0] jp4, input logic [25:0] jidx);
        longint unsigned t;
        if (bt) begin
            t = (longint'(bp4) + longint'(bimm) * 4) % 64'h1_0000_0000;
            m_pc    = 32'(t) & ~32'h3;
            m_instr = TB_NOP;
            m_valid = 1'b0;
        end else if (j) begin
            m_pc    = (jp4 & 32'hF000_0000) | (32'(jidx) * 4);
            m_instr = TB_NOP;
            m_valid = 1'b0;
        end else if (!s) begin
            m_instr = mem_word(m_pc);
            m_pp4   = 32'(({32'd0, m_pc} + 64'd4) % 64'h1_0000_0000);
            m_valid = 1'b1;
            m_fc    = m_fc + 1;
            m_pc    = m_pp4;
        end
    endtask

    initial begin
        vec_t v;
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_reset_state("reset");

        //        stall bt  br_pc4        imm           j  j_pc4         jidx          exp_pc        exp_instr                 exp_pp4      chk v  fc
        vecs.push_back(mk(0, 0, 0,            0,            0, 0,            0,            32'h4,        32'h2008_0005,            32'h4,       1, 1, 1));
        vecs.push_back(mk(0, 0, 0,            0,            0, 0,            0,            32'h8,        mem_word(32'h4),          32'h8,       1, 1, 2));
        vecs.push_back(mk(0, 0, 0,            0,            0, 0,            0,            32'hC,        mem_word(32'h8),          32'hC,       1, 1, 3));
        vecs.push_back(mk(1, 0, 0,            0,            0, 0,            0,            32'hC,        mem_word(32'h8),          32'hC,       1, 1, 3));
        vecs.push_back(mk(1, 0, 0,            0,            0, 0,            0,            32'hC,        mem_word(32'h8),          32'hC,       1, 1, 3));
        vecs.push_back(mk(1, 0, 0,            0,            0, 0,            0,            32'hC,        mem_word(32'h8),          32'hC,       1, 1, 3));
        vecs.push_back(mk(1, 1, 32'h10,       32'hFFFF_FFFE,0, 0,            0,            32'h8,        TB_NOP,                   0,           0, 0, 3));
        vecs.push_back(mk(0, 0, 0,            0,            0, 0,            0,            32'hC,        mem_word(32'h8),          32'hC,       1, 1, 4));
        vecs.push_back(mk(0, 0, 0,            0,            1, 32'h4000_0010,26'h10,       32'h4000_0040,TB_NOP,                   0,           0, 0, 4));
        vecs.push_back(mk(0, 0, 0,            0,            0, 0,            0,            32'h4000_0044,mem_word(32'h4000_0040),  32'h4000_0044,1,1, 5));
        vecs.push_back(mk(0, 1, 32'h100,      32'h4,        1, 32'h4000_0010,26'h10,       32'h110,      TB_NOP,                   0,           0, 0, 5));
        vecs.push_back(mk(0, 1, 32'h203,      32'h1,        0, 0,            0,            32'h204,      TB_NOP,                   0,           0, 0, 5));
        vecs.push_back(mk(0, 0, 0,            0,            0, 0,            0,            32'h208,      mem_word(32'h204),        32'h208,     1, 1, 6));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFC,32'h0,        0, 0,            0,            32'hFFFF_FFFC,TB_NOP,                   0,           0, 0, 6));
        vecs.push_back(mk(0, 0, 0,            0,            0, 0,            0,            32'h0,        mem_word(32'hFFFF_FFFC),  32'h0,       1, 1, 7));
        vecs.push_back(mk(0, 0, 0,            0,            1, 32'hA000_0000,26'h3FF_FFFF, 32'hAFFF_FFFC,TB_NOP,                   0,           0, 0, 7));
        vecs.push_back(mk(0, 0, 0,            0,            0, 0,            0,            32'hB000_0000,mem_word(32'hAFFF_FFFC),  32'hB000_0000,1,1, 8));

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            v = vecs[i];
            tag = $sformatf("vec%0d", i);
            drive(v.stall, v.br_taken, v.br_pc_plus4, v.br_sign_imm, v.jump,
                  v.jump_pc_plus4, v.jump_index);
            @(posedge clk);
            #1;
            check32({tag, "_pc"}, pc, v.exp_pc);
            check32({tag, "_addr"}, imem_addr, v.exp_pc);
            check32({tag, "_instr"}, if_id_instr, v.exp_instr);
            check32({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, v.exp_valid});
            check32({tag, "_fc"}, fetch_count, v.exp_fc);
            if (v.chk_pp4) check32({tag, "_pp4"}, if_id_pc_plus4, v.exp_pp4);
            @(negedge clk);
        end

        // Reset between edges, with a stalled redirect pending.
        drive(1, 1, 32'h1000, 32'h8, 1, 32'h3000_0000, 26'h55);
        #1;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(posedge clk);
        #1;
        check_reset_state("reset_over_redirect");
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check32("first_adv_pc", pc, 32'h4);
        check32("first_adv_instr", if_id_instr, 32'h2008_0005);
        check32("first_adv_pp4", if_id_pc_plus4, 32'h4);
        check32("first_adv_valid", {31'd0, if_id_valid}, 32'h1);
        check32("first_adv_fc", fetch_count, 32'h1);

        // Randomized phase against the reference model.
        m_pc = 32'h4; m_instr = 32'h2008_0005; m_pp4 = 32'h4; m_valid = 1'b1; m_fc = 32'h1;
        for (int n = 0; n < 400; n++) begin
            logic        s, bt, j;
            logic [31:0] bp4, bimm, jp4;
            logic [25:0] jidx;
            @(negedge clk);
            s    = ($urandom_range(0, 3) == 0);
            bt   = ($urandom_range(0, 7) == 0);
            j    = ($urandom_range(0, 7) == 0);
            bp4  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                : $urandom;
            bimm = 32'($signed($urandom_range(0, 64)) - 32);
            jp4  = $urandom;
            jidx = 26'($urandom);
            drive(s, bt, bp4, bimm, j, jp4, jidx);
            model_step(s, bt, bp4, bimm, j, jp4, jidx);
            exp_q.push_back(m_pc);
            exp_q.push_back(m_instr);
            @(posedge clk);
            #1;
            check32("rnd_pc", pc, exp_q.pop_front());
            check32("rnd_instr", if_id_instr, exp_q.pop_front());
            check32("rnd_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
            check32("rnd_fc", fetch_count, m_fc);
            if (m_valid) check32("rnd_pp4", if_id_pc_plus4, m_pp4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
